// File: rtl/mudi_if.sv
// mudi_if: request/result bundle between the E-stage and the multiply/divide unit.
//   Start  1   one-cycle launch pulse
//   Op     3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved
//   A, B   32  forwarded rs / rt operands
//   Busy   1   MuDiBusy to the hazard unit (combinational on Start)
//   HI, LO 32  architectural HI/LO registers
interface mudi_if;
  logic        Start;
  logic [2:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, Op, A, B, input Busy, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mudi_unit.sv
// mudi_unit: fixed-latency multiply/divide unit holding HI/LO.
//   Clk    clock
//   Reset  synchronous, active-high
//   bus    mudi_if.slave (Start/Op/A/B in, Busy/HI/LO out)
// The result is computed combinationally at the Start edge and parked in
// PendHI/PendLO; the down-counter only models the architectural latency.
module mudi_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic   Clk,
  input  logic   Reset,
  mudi_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] hi, lo, pend_hi, pend_lo;

  logic        is_mudi;
  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, dvs_s, dvs_u;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;

  // Ops 0..3 are the multi-cycle class.
  assign is_mudi = ~bus.Op[2];

  assign bus.Busy = (bus.Start && is_mudi && state == IDLE) || state == BUSY;
  assign bus.HI   = hi;
  assign bus.LO   = lo;

  always_comb begin
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // Signed divide via magnitudes; the 0x80000000 / -1 case falls out
    // naturally (quotient wraps to 0x80000000, remainder 0).
    a_mag  = bus.A[31] ? -bus.A : bus.A;
    b_mag  = bus.B[31] ? -bus.B : bus.B;
    // Divisor forced non-zero so the divider never sees 0; the B==0 result is muxed below.
    dvs_s  = (bus.B == 32'd0) ? 32'd1 : b_mag;
    dvs_u  = (bus.B == 32'd0) ? 32'd1 : bus.B;
    q_mag  = a_mag / dvs_s;
    r_mag  = a_mag % dvs_s;
    q_s    = (bus.A[31] ^ bus.B[31]) ? -q_mag : q_mag;
    r_s    = bus.A[31] ? -r_mag : r_mag;
    q_u    = bus.A / dvs_u;
    r_u    = bus.A % dvs_u;

    res_hi = 32'd0;
    res_lo = 32'd0;
    case (bus.Op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_hi = r_s;
        res_lo = q_s;
      end
      default: begin
        res_hi = r_u;
        res_lo = q_u;
      end
    endcase
    if (bus.Op[1] && bus.B == 32'd0) begin
      res_hi = bus.A;
      res_lo = 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            if (is_mudi) begin
              pend_hi <= res_hi;
              pend_lo <= res_lo;
              cnt     <= bus.Op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              state   <= BUSY;
            end else if (bus.Op == OP_MTHI) begin
              hi <= bus.A;
            end else if (bus.Op == OP_MTLO) begin
              lo <= bus.A;
            end
          end
        end
        BUSY: begin
          // Start is ignored here; the hazard unit never issues one.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mudi_unit.md
# mudi_unit

Multiply/divide unit for the five-stage MIPS pipeline. It executes mult/multu/div/divu with fixed multi-cycle latency and mthi/mtlo in a single cycle, and holds the architectural HI/LO registers. It sits in the E stage beside the ALU. Its Busy output is the MuDiBusy signal the hazard unit uses to stall D-stage mf/mt/mudi instructions. HI/LO feed the E-stage mfhi/mflo result mux.

## Interface
- MULT_CYCLES, 5: busy cycles after Start for mult/multu (1..15).
- DIV_CYCLES, 10: busy cycles after Start for div/divu (1..15).

- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle pulse from E-stage decode; launches the operation in Op.
- Op  in  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 reserved.
- A  in  32  rs operand, already forwarded.
- B  in  32  rt operand, already forwarded.
- Busy  out  1  Start-of-mult/div OR internal busy state; drives hazard MuDiBusy.
- HI  out  32  architectural HI register.
- LO  out  32  architectural LO register.

## Operation
- States: IDLE, BUSY. The 4-bit counter Cnt counts down remaining cycles.
- IDLE + Start + Op∈{0..3}:
  - Compute the result combinationally from A/B and latch it into PendHI/PendLO.
  - Load Cnt with MULT_CYCLES or DIV_CYCLES, then go to BUSY.
- IDLE + Start + Op=4: HI<=A at this edge. Op=5: LO<=A. Stay IDLE; Busy is not asserted.
- IDLE + Start + Op∈{6,7}: no effect.
- BUSY: Cnt decrements each cycle. When Cnt==1, commit HI<=PendHI, LO<=PendLO and return to IDLE.
- Start while BUSY is ignored. The hazard unit guarantees this never occurs; the bench asserts it never happens.
- Arithmetic rules:
  - mult: signed 32x32 to 64, {HI,LO}=product.
  - multu: unsigned 32x32 to 64.
  - div: LO=signed quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (B==0), div or divu: LO=32'hFFFFFFFF, HI=A.
  - Signed overflow (A=32'h80000000, B=32'hFFFFFFFF): LO=32'h80000000, HI=0.
- Operands are sampled only at the Start edge. Later changes on A/B do not affect the pending result.

## Timing
- Reset: state IDLE, Cnt=0, HI=0, LO=0, PendHI=PendLO=0, Busy=0 in the following cycle. Reset mid-operation abandons the pending result and leaves HI/LO at 0.
- Busy = (Start && Op∈{0..3} && state==IDLE) || state==BUSY. It is combinational on Start so that a mudi-class instruction directly behind the starting one in D stalls at once.
- Start sampled at edge t0: Busy is high during cycle t0 (the Start cycle) and during cycles t0+1..t0+N, where N is the configured latency.
- HI/LO update on the edge ending cycle t0+N. The new values and Busy=0 are visible in cycle t0+N+1.
- Total Busy duration is N+1 cycles: mult 6 cycles, div 11 cycles at default parameters.
- mthi/mtlo at edge t0: the new value is visible in cycle t0+1, with zero Busy cycles.
- HI/LO never change except at a commit, an mthi/mtlo write, or Reset.

## Test plan
- Reset, then mult A=3, B=32'hFFFFFFFE:
  - Busy is high for exactly 6 cycles.
  - Then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA.
  - HI/LO hold their old value while Busy is high.
- multu A=B=32'hFFFFFFFF: HI=32'hFFFFFFFE, LO=32'h00000001 after 6 Busy cycles.
- div A=-7 (32'hFFFFFFF9), B=2:
  - 11 Busy cycles.
  - LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- Divide edge cases:
  - divu A=7, B=0: LO=32'hFFFFFFFF, HI=7.
  - div A=32'h80000000, B=32'hFFFFFFFF: LO=32'h80000000, HI=0.
- Operand and mt behaviour:
  - mthi A=32'h12345678 gives HI=32'h12345678 next cycle with Busy never high.
  - Changing A/B during BUSY leaves the committed result unchanged.
- Reset mid-operation and Start-while-busy:
  - Reset asserted in the 3rd Busy cycle of a div gives Busy=0, HI=LO=0 the next cycle, with no later commit.
  - A Start pulse injected during BUSY is ignored, and the first result commits on schedule.
